pwm_dimmer_mc: RTL and testbench
================================

Name: pwm_dimmer_mc

Overview:
Multi-channel PWM LED dimmer. All channels share one prescaler and one period counter, and each channel has its own duty cycle. Duty writes are shadowed and applied only at period boundaries, so no runt or glitch pulses occur. An optional per-channel fade mode ramps the active duty toward a target by one LSB per period. The block sits between the register/control logic and the LED pad drivers.

Parameters:
CHANNELS, 4, number of independent PWM outputs (1..16).
RES, 8, counter resolution in bits; the period is 2^RES counter ticks.
PRESC_W, 8, width of the prescale input.
CH_W, 2, width of wr_ch; must satisfy 2^CH_W >= CHANNELS.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
en  in  1  global enable; low holds the counters and outputs cleared.
prescale  in  PRESC_W  counter advances every prescale+1 clk cycles; sampled live.
wr_en  in  1  one-cycle duty write strobe.
wr_ch  in  CH_W  target channel of the write.
wr_duty  in  RES+1  new target duty; valid range 0..2^RES.
wr_fade  in  1  1 = ramp to target; 0 = jump to target.
pwm  out  CHANNELS  registered PWM outputs.
period_tick  out  1  registered one-cycle pulse at each period boundary.
fade_done  out  CHANNELS  per channel, active duty equals target duty.

Behaviour:
- Reset values:
  - presc_cnt = 0, ctr = 0, pwm = 0, period_tick = 0.
  - duty_act = 0 and duty_tgt = 0 for all channels; fade flags = 0.
  - fade_done = all ones.
- Tick: tick = en && (presc_cnt == prescale).
  - On tick, presc_cnt <= 0; otherwise presc_cnt <= presc_cnt+1.
  - If prescale drops below presc_cnt, the count wraps naturally through 2^PRESC_W. No special handling.
- Counter: on tick, ctr <= ctr+1, wrapping 2^RES-1 -> 0.
- Boundary: boundary = tick && (ctr == 2^RES-1). period_tick <= boundary.
- Writes:
  - wr_en with wr_ch < CHANNELS: duty_tgt[wr_ch] <= min(wr_duty, 2^RES) and fade[wr_ch] <= wr_fade.
  - wr_ch >= CHANNELS: the write is ignored.
  - Writes are accepted every cycle, whether en is high or low.
- Duty next value, per channel: duty_nxt = fade ? duty_act ±1 toward tgt (hold if equal) : tgt. tgt here is the write-through value, meaning a write in the boundary cycle is used at that boundary.
  - On boundary, duty_act <= duty_nxt.
  - Between boundaries, duty_act is held, so a mid-period write never alters the current period.
- PWM output: on tick, pwm[ch] <= (ctr_nxt < duty_used), where duty_used = duty_nxt on boundary, else duty_act.
  - duty 0 gives constant low.
  - duty 2^RES gives constant high.
  - duty d gives d high ticks then 2^RES-d low ticks per period, with high leading.
- After reset or en rising: the first slot (ctr=0) is low because pwm starts at 0. Exact waveforms start at the first boundary.
- en low (synchronous):
  - presc_cnt, ctr, pwm and period_tick are cleared to 0.
  - duty_act <= duty_tgt immediately (no fade) for all channels.
  - fade flags are kept.
- fade_done[ch] = (duty_act[ch] == duty_tgt[ch]), decoded from registers with no extra latency. A fade from a to b completes after |a-b| boundaries.
- Asynchronous reset mid-period or mid-fade: all state returns to the reset values immediately. No partial write survives.

Test Plan:
- RES=4, CHANNELS=2, prescale=0, en=1. Write ch0 duty=5 (no fade) and ch1 duty=16. After the first boundary, check per 16-cycle period: pwm[0] high 5 cycles then low 11; pwm[1] constantly high; period_tick pulses every 16 cycles.
- prescale=2, ch0 duty=8 → period is 48 clk; pwm[0] high for 24 cycles, low for 24.
- Write ch0 duty=12 at ctr=3 while the active duty is 4 → the current period still shows 4 high ticks; the next period shows 12. Repeat with the write landing exactly in the boundary cycle → 12 applies in the very next period.
- Fade: ch1 active=2, write duty=6 with wr_fade=1 → over the following periods, high widths are 3, 4, 5, 6. fade_done[1] is low until the 4th boundary, then high.
- Write wr_ch=3 with CHANNELS=2 → no state change. Write wr_duty=31 → clamped to 16, output constant high.
- Drop en mid-period → pwm=0 and ctr=0 on the next clk; a pending fade snaps to target and fade_done goes all ones. Assert rst_n mid-fade → all outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pwm_dimmer_mc.sv
// pwm_dimmer_mc: multi-channel PWM LED dimmer with shadowed duty and fade.
//
// One prescaler and one RES-bit period counter are shared by all channels.
// Each channel keeps a target duty (written at any time) and an active duty
// (used for the waveform). The active duty only changes at period
// boundaries, so an output never shows a runt or glitch pulse. In fade mode
// the active duty moves one LSB per period toward the target.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           global enable; low clears counters/outputs, snaps duties
//   prescale     counter advances every prescale+1 clk cycles (live)
//   wr_en        one-cycle duty write strobe
//   wr_ch        channel of the write (>= CHANNELS is ignored)
//   wr_duty      new target duty, clamped to 2^RES
//   wr_fade      1 = ramp to target, 0 = jump to target
//   pwm          registered PWM outputs
//   period_tick  registered one-cycle pulse at each period boundary
//   fade_done    per channel, active duty equals target duty
module pwm_dimmer_mc #(
  parameter int CHANNELS = 4,
  parameter int RES      = 8,
  parameter int PRESC_W  = 8,
  parameter int CH_W     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PRESC_W-1:0]  prescale,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [RES:0]        wr_duty,
  input  logic                wr_fade,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_tick,
  output logic [CHANNELS-1:0] fade_done
);

  localparam logic [RES:0]     DUTY_MAX  = {1'b1, {RES{1'b0}}};
  localparam logic [RES:0]     DUTY_ONE  = 1;
  localparam logic [RES-1:0]   CTR_MAX   = '1;
  localparam logic [RES-1:0]   CTR_ONE   = 1;
  localparam logic [PRESC_W-1:0] PRESC_ONE = 1;

  logic [PRESC_W-1:0] presc_cnt;
  logic [RES-1:0]     ctr;
  logic [RES-1:0]     ctr_nxt;
  logic               tick;
  logic               boundary;
  logic [RES:0]       wr_duty_clamp;

  logic [RES:0]       duty_act  [CHANNELS];
  logic [RES:0]       duty_tgt  [CHANNELS];
  logic [RES:0]       tgt_wt    [CHANNELS];
  logic [RES:0]       duty_nxt  [CHANNELS];
  logic [RES:0]       duty_used [CHANNELS];
  logic [CHANNELS-1:0] fade;
  logic [CHANNELS-1:0] fade_wt;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] pwm_nxt;

  assign tick          = en && (presc_cnt == prescale);
  assign ctr_nxt       = ctr + CTR_ONE;
  assign boundary      = tick && (ctr == CTR_MAX);
  assign wr_duty_clamp = (wr_duty > DUTY_MAX) ? DUTY_MAX : wr_duty;

  // Target and fade flag are write-through so a write landing in the
  // boundary cycle already takes effect at that boundary.
  always_comb begin
    wr_hit    = '0;
    fade_wt   = '0;
    pwm_nxt   = '0;
    tgt_wt    = '{default: '0};
    duty_nxt  = '{default: '0};
    duty_used = '{default: '0};
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i]  = wr_en && (int'(wr_ch) == i);
      tgt_wt[i]  = wr_hit[i] ? wr_duty_clamp : duty_tgt[i];
      fade_wt[i] = wr_hit[i] ? wr_fade : fade[i];
      if (!fade_wt[i])
        duty_nxt[i] = tgt_wt[i];
      else if (duty_act[i] < tgt_wt[i])
        duty_nxt[i] = duty_act[i] + DUTY_ONE;
      else if (duty_act[i] > tgt_wt[i])
        duty_nxt[i] = duty_act[i] - DUTY_ONE;
      else
        duty_nxt[i] = duty_act[i];
      duty_used[i] = boundary ? duty_nxt[i] : duty_act[i];
      // Extra MSB lets duty 2^RES compare above every counter value.
      pwm_nxt[i]   = ({1'b0, ctr_nxt} < duty_used[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt   <= '0;
      ctr         <= '0;
      pwm         <= '0;
      period_tick <= 1'b0;
      fade        <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act[i] <= '0;
        duty_tgt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_tgt[i] <= tgt_wt[i];
      end
      fade <= fade_wt;
      if (!en) begin
        presc_cnt   <= '0;
        ctr         <= '0;
        pwm         <= '0;
        period_tick <= 1'b0;
        // Disabled: pending fades snap to their (post-write) target.
        for (int i = 0; i < CHANNELS; i++) begin
          duty_act[i] <= tgt_wt[i];
        end
      end else begin
        period_tick <= boundary;
        if (tick) begin
          presc_cnt <= '0;
          ctr       <= ctr_nxt;
          pwm       <= pwm_nxt;
        end else begin
          presc_cnt <= presc_cnt + PRESC_ONE;
        end
        if (boundary) begin
          for (int i = 0; i < CHANNELS; i++) begin
            duty_act[i] <= duty_nxt[i];
          end
        end
      end
    end
  end

  always_comb begin
    fade_done = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fade_done[i] = (duty_act[i] == duty_tgt[i]);
    end
  end

endmodule

// File: tb/tb_pwm_dimmer_mc.sv
// Bench for pwm_dimmer_mc with RES=4, CHANNELS=2. The stimulus pushes the
// expected shape of specific periods (length, high cycles per channel,
// fade_done at period start) into a queue; the monitor measures every
// period delimited by period_tick and compares it against the queue entry
// tagged with that period index.
module tb_pwm_dimmer_mc;

  localparam int CHANNELS = 2;
  localparam int RES      = 4;
  localparam int PRESC_W  = 8;
  localparam int CH_W     = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [PRESC_W-1:0]  prescale;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [RES:0]        wr_duty;
  logic                wr_fade;
  logic [CHANNELS-1:0] pwm;
  logic                period_tick;
  logic [CHANNELS-1:0] fade_done;

  pwm_dimmer_mc #(
    .CHANNELS(CHANNELS), .RES(RES), .PRESC_W(PRESC_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty), .wr_fade(wr_fade),
    .pwm(pwm), .period_tick(period_tick), .fade_done(fade_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pnum;
    int         len;
    int         h0;
    int         h1;
    logic [1:0] fd;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   p_idx       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int p, input int len, input int h0, input int h1, input logic [1:0] fd);
    exp_t e;
    e.pnum = p; e.len = len; e.h0 = h0; e.h1 = h1; e.fd = fd;
    q.push_back(e);
  endtask

  // Monitor: measure each complete period between period_tick pulses.
  bit         in_period = 0;
  int         m_len, m_h0, m_h1;
  bit         m_mono;
  logic [1:0] m_fd;
  logic [1:0] m_prev;

  always @(negedge clk) begin
    if (!rst_n || !en) begin
      in_period = 0;
    end else begin
      if (period_tick) begin
        if (in_period) begin
          while (q.size() > 0 && q[0].pnum < p_idx) begin
            chk($sformatf("period%0d_missed", q[0].pnum), 0, 1);
            void'(q.pop_front());
          end
          if (q.size() > 0 && q[0].pnum == p_idx) begin
            chk($sformatf("p%0d_len", p_idx), m_len, q[0].len);
            chk($sformatf("p%0d_high0", p_idx), m_h0, q[0].h0);
            chk($sformatf("p%0d_high1", p_idx), m_h1, q[0].h1);
            chk($sformatf("p%0d_fade_done", p_idx), {30'd0, m_fd}, {30'd0, q[0].fd});
            chk($sformatf("p%0d_high_leading", p_idx), {31'd0, m_mono}, 1);
            void'(q.pop_front());
          end
          p_idx++;
        end
        in_period = 1;
        m_len = 0; m_h0 = 0; m_h1 = 0; m_mono = 1;
        m_fd = fade_done; m_prev = 2'b11;
      end
      if (in_period) begin
        m_len++;
        if (pwm[0]) m_h0++;
        if (pwm[1]) m_h1++;
        if ((pwm & ~m_prev) != 2'b00) m_mono = 0;
        m_prev = pwm;
      end
    end
  end

  task automatic wr(input int ch, input int duty, input bit f, input int k);
    repeat (k) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_ch = ch[CH_W-1:0]; wr_duty = duty[RES:0]; wr_fade = f;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Returns just after the negedge of a cycle with period_tick high (ctr=0).
  task automatic sync();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!period_tick && n < 2000);
    if (!period_tick) begin
      vectors++;
      miscompares++;
      $display("FAIL sync_timeout: no period_tick within %0d cycles", n);
    end
  endtask

  int cur;

  initial begin
    rst_n = 1'b0; en = 1'b0; prescale = '0;
    wr_en = 1'b0; wr_ch = '0; wr_duty = '0; wr_fade = 1'b0;
    #12;
    chk("rst_pwm", {30'd0, pwm}, 0);
    chk("rst_period_tick", {31'd0, period_tick}, 0);
    chk("rst_fade_done", {30'd0, fade_done}, 3);

    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1;
    wr(0, 5, 0, 0);
    wr(1, 16, 0, 0);
    chk("pre_boundary_fade_done", {30'd0, fade_done}, 0);

    sync();
    cur = p_idx;
    push(cur,     16, 5,  16, 2'b11);
    push(cur + 1, 16, 4,  16, 2'b11);
    push(cur + 2, 16, 12, 16, 2'b11);
    push(cur + 3, 16, 7,  16, 2'b11);
    push(cur + 4, 16, 7,  2,  2'b11);
    push(cur + 5, 16, 7,  3,  2'b01);
    push(cur + 6, 16, 7,  4,  2'b01);
    push(cur + 7, 16, 7,  5,  2'b01);
    push(cur + 8, 16, 7,  6,  2'b11);
    push(cur + 9, 16, 16, 6,  2'b11);
    push(cur + 11, 48, 24, 18, 2'b11);
    push(cur + 12, 48, 24, 18, 2'b11);

    wr(0, 4, 0, 2);                      // period cur: sets up active=4
    sync(); wr(0, 12, 0, 3);             // cur+1: mid-period write, still 4
    sync(); wr(0, 7, 0, 15);             // cur+2: write in boundary cycle
    sync(); wr(1, 2, 0, 1);              // cur+3
    sync(); wr(1, 6, 1, 5);              // cur+4: fade 2 -> 6
    chk("fade_start_done", {30'd0, fade_done}, 1);
    sync(); sync(); sync();              // cur+7
    chk("fade_mid_done", {30'd0, fade_done}, 1);
    sync();                              // cur+8
    wr(3, 0, 0, 2);
    wr(2, 3, 0, 0);
    chk("bad_ch_ignored", {30'd0, fade_done}, 3);
    wr(0, 31, 0, 0);                     // clamps to 16
    sync(); sync();                      // cur+10
    wr(0, 8, 0, 1);
    prescale = 8'd2;
    sync(); sync();                      // cur+12
    wr(1, 0, 1, 1);                      // fade ch1 6 -> 0
    sync();                              // cur+13, ch1 active 5
    repeat (7) @(posedge clk);
    #1;
    chk("pre_disable_fade_done", {30'd0, fade_done}, 1);
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    chk("dis_pwm", {30'd0, pwm}, 0);
    chk("dis_period_tick", {31'd0, period_tick}, 0);
    chk("dis_ctr", {28'd0, dut.ctr}, 0);
    chk("dis_fade_snap", {30'd0, fade_done}, 3);

    prescale = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    sync();
    cur = p_idx;
    push(cur, 16, 8, 0, 2'b11);
    wr(0, 15, 1, 2);                     // fade ch0 8 -> 15
    sync();                              // cur+1, ch0 active 9, ctr=0
    chk("pre_rst_pwm", {30'd0, pwm}, 1);
    chk("pre_rst_fade_done", {30'd0, fade_done}, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", {30'd0, pwm}, 0);
    chk("async_rst_period_tick", {31'd0, period_tick}, 0);
    chk("async_rst_fade_done", {30'd0, fade_done}, 3);
    #20;
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
